// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch, decode, execute, memory and write-back.
// Optional illegal-opcode trap state is built when MULTI_CYCLE_CTRL_TRAP_EN is defined.
`timescale 1ns/1ps

module multi_cycle_ctrl #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic [OP_W-1:0]    instr_op_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               mem_addr_sel_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               pc_cond_o,
    output logic               bne_o,
    output logic               reg_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic               zero_ext_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               busy_o,
    output logic               trap_o
);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(15);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(7);

    localparam logic [1:0] SRC_B_RT    = 2'd0;
    localparam logic [1:0] SRC_B_FOUR  = 2'd1;
    localparam logic [1:0] SRC_B_IMM   = 2'd2;
    localparam logic [1:0] SRC_B_IMMSH = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
        , S_TRAP
`endif
    } state_e;

    // Instruction class is captured once in DECODE so later states do not
    // depend on the IR staying stable.
    typedef enum logic [3:0] {
        CLS_R,
        CLS_ADDI,
        CLS_ORI,
        CLS_LUI,
        CLS_BEQ,
        CLS_BNE,
        CLS_LW,
        CLS_SW,
        CLS_BAD
    } cls_e;

    state_e state_q, state_d;
    cls_e   cls_q, cls_d;
    cls_e   dec_cls;
    state_e boundary_state;

    function automatic cls_e decode_op(input logic [OP_W-1:0] op);
        case (op)
            OP_RTYPE: decode_op = CLS_R;
            OP_ADDI:  decode_op = CLS_ADDI;
            OP_ORI:   decode_op = CLS_ORI;
            OP_LUI:   decode_op = CLS_LUI;
            OP_BEQ:   decode_op = CLS_BEQ;
            OP_BNE:   decode_op = CLS_BNE;
            OP_LW:    decode_op = CLS_LW;
            OP_SW:    decode_op = CLS_SW;
            default:  decode_op = CLS_BAD;
        endcase
    endfunction

    assign dec_cls        = decode_op(instr_op_i);
    assign boundary_state = run_i ? S_FETCH : S_IDLE;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_BAD;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // NOTE: every output and next-state variable gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        pc_cond_o      = 1'b0;
        bne_o          = 1'b0;
        reg_write_o    = 1'b0;
        reg_dst_o      = 1'b0;
        mem_to_reg_o   = 1'b0;
        alu_src_a_o    = 1'b0;
        alu_src_b_o    = SRC_B_RT;
        zero_ext_o     = 1'b0;
        alu_op_o       = ALU_ADD;
        trap_o         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = SRC_B_FOUR;
                alu_op_o    = ALU_ADD;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end

            S_DECODE: begin
                alu_src_b_o = SRC_B_IMMSH;
                alu_op_o    = ALU_ADD;
                cls_d       = dec_cls;
                case (dec_cls)
                    CLS_R, CLS_ADDI, CLS_ORI, CLS_LUI: state_d = S_EXEC;
                    CLS_BEQ, CLS_BNE:                  state_d = S_BRANCH;
                    CLS_LW, CLS_SW:                    state_d = S_ADDR;
`ifdef MULTI_CYCLE_CTRL_TRAP_EN
                    default:                           state_d = S_TRAP;
`else
                    default:                           state_d = boundary_state;
`endif
                endcase
            end

            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = (cls_q == CLS_R) ? SRC_B_RT : SRC_B_IMM;
                zero_ext_o  = (cls_q == CLS_ORI);
                case (cls_q)
                    CLS_R:   alu_op_o = ALU_FUNCT;
                    CLS_ORI: alu_op_o = ALU_OR;
                    CLS_LUI: alu_op_o = ALU_LUI;
                    default: alu_op_o = ALU_ADD;
                endcase
                state_d = S_WB_ALU;
            end

            S_WB_ALU: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (cls_q == CLS_R);
                state_d     = boundary_state;
            end

            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_RT;
                alu_op_o    = ALU_SUB;
                pc_cond_o   = 1'b1;
                bne_o       = (cls_q == CLS_BNE);
                state_d     = boundary_state;
            end

            S_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_ADD;
                state_d     = (cls_q == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                if (mem_ready_i) state_d = S_WB_MEM;
            end

            S_MEM_WR: begin
                mem_req_o      = 1'b1;
                mem_we_o       = 1'b1;
                mem_addr_sel_o = 1'b1;
                if (mem_ready_i) state_d = boundary_state;
            end

            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = boundary_state;
            end

`ifdef MULTI_CYCLE_CTRL_TRAP_EN
            S_TRAP: begin
                trap_o = 1'b1;
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q != S_IDLE);

    // A pending access keeps its request and attributes until acknowledged.
    a_mem_hold: assert property (@(posedge clk_i) disable iff (!rst_i)
        (mem_req_o && !mem_ready_i) |=>
            (mem_req_o && $stable(mem_we_o) && $stable(mem_addr_sel_o)));

    a_we_excl: assert property (@(posedge clk_i) disable iff (!rst_i)
        $onehot0({ir_write_o | pc_write_o, pc_cond_o, reg_write_o}) &&
        (ir_write_o == pc_write_o));

endmodule
